store_commit_queue: RTL and testbench
=====================================

// Module: store_commit_queue
// PURPOSE
//  Buffers executed stores (addr/data/strobe) in program order between execute and commit; writes nothing to memory speculatively.
//  When commit stage asserts commit_store_valid (ROB head/next in Store_Wait), issues the oldest store to the dcache write port.
//  Returns one-cycle commit_store_ready plus any dcache/TLB exception (commit_store_ex) so commit can retire or trap.
//  Flush discards all uncommitted entries; an address-accepted write drains silently.
// PARAMETERS
//  SQ_DEPTH   4   store entries, power of two, >=2
//  ADDR_W     32  address/data width
// PORTS
//  clk               in   1       clock
//  reset             in   1       synchronous, active-high reset
//  flush             in   1       pipeline flush from commit stage
//  sq_enq_valid      in   1       execute presents a non-excepting store
//  sq_enq_ready      out  1       queue not full
//  sq_enq_addr       in   32      store virtual address
//  sq_enq_wdata      in   32      store data, byte-lane aligned
//  sq_enq_wstrb      in   4       byte enables
//  sq_enq_size       in   2       0=byte 1=half 2=word
//  commit_store_valid in  1       commit stage requests oldest store write
//  commit_store_ready out 1       one-cycle pulse: head store finished
//  commit_store_ex   out  exception_t  exception of finished store (zero unless ex)
//  dc_req            out  1       dcache write request
//  dc_addr/dc_wdata  out  32/32   head entry addr/data
//  dc_wstrb/dc_size  out  4/2     head entry strobe/size
//  dc_addr_ok        in   1       request accepted this cycle
//  dc_ex             in   1       with dc_addr_ok: TLB/address exception, no data phase
//  dc_exccode        in   5       exccode when dc_ex
//  dc_tlb_refill     in   1       refill flag when dc_ex
//  dc_data_ok        in   1       write completed
//  sq_empty          out  1       no entries held
// BEHAVIOUR
//  Reset: pointers/count 0, state IDLE; sq_enq_ready=1, sq_empty=1, commit_store_ready=0, commit_store_ex='0, dc_req=0.
//  Queue: circular, head/tail $clog2(SQ_DEPTH) bits wrapping naturally; count $clog2(SQ_DEPTH)+1 bits.
//   enq when sq_enq_valid&&sq_enq_ready; sq_enq_ready = count!=SQ_DEPTH (registered count, not dequeue-forwarded).
//   Simultaneous enq+deq: count unchanged, both pointers advance.
//  FSM IDLE/REQ/RESP/DONE/DRAIN:
//   IDLE: commit_store_valid && !flush && count!=0 -> REQ. commit_store_valid with empty queue: stay IDLE (bench assertion).
//   REQ: dc_req=1, dc_* driven from head entry. dc_addr_ok&&!dc_ex -> RESP. dc_addr_ok&&dc_ex -> DONE with ex latched.
//   RESP: dc_req=0; dc_data_ok -> DONE.
//   DONE (1 cycle): commit_store_ready=1; commit_store_ex={ex,exccode,badvaddr=head addr,tlb_refill} if ex else '0;
//     head++ , count-- ; -> IDLE. Excepting store still dequeued (commit flushes next).
//  Latency: commit_store_valid at cycle 0 -> dc_req cycle 1; addr_ok cycle a, data_ok cycle d -> ready cycle d+1.
//  flush (priority over enq): count/head/tail -> 0, entries invalid.
//   in IDLE/REQ/DONE: -> IDLE, dc_req dropped same cycle, no ready pulse.
//   in RESP (address accepted): -> DRAIN; DRAIN holds until dc_data_ok, then IDLE; ready never pulsed; sq_enq_ready=0 in DRAIN.
//   flush coincident with dc_addr_ok in REQ: treat as accepted -> DRAIN.
//  commit_store_ready never asserts in consecutive cycles; outputs glitch-free (from state regs).
//  reset mid-transaction: immediate IDLE; dcache-side cleanup is dcache's responsibility (both share reset).
// STRUCTURE
//  Package (cpu.svh): exception_t (existing), sq_entry_t {addr,wdata,wstrb,size}, sq_state_t enum, EXCCODE_* constants.
//  Sub-module: sq_fifo (generic circular buffer: enq/deq/flush/count); FSM and dcache handshake in this module.
// TESTING
//  Enqueue 2 stores (0x1000/0xAABBCCDD/4'hF, 0x1004/0x11/4'h1); commit_store_valid; addr_ok c2, data_ok c4 -> ready pulse c5, dc_addr 0x1000, count 1.
//  Fill 4 entries -> sq_enq_ready=0; 5th enq held; complete one store -> ready cycle after DONE, 5th accepted, tail wraps to 1.
//  Commit with dc_addr_ok&dc_ex, exccode 5'h3, tlb_refill=1 -> ready pulse with ex=1, badvaddr=head addr, no data phase, entry dequeued.
//  Flush while REQ (no addr_ok) -> dc_req low same cycle, queue empty, no ready; later commit_store_valid ignored.
//  Flush in RESP -> DRAIN, sq_enq_ready=0 until data_ok, no ready pulse, then IDLE with sq_empty=1.
//  Back-to-back commits with 0-wait dcache (addr_ok in REQ cycle, data_ok next): ready pulses never adjacent; enq/deq same cycle keeps count.

Source files
------------

// File: rtl/store_commit_queue_pkg.sv
// Shared types for the store commit queue: exception record, queue entry and FSM encoding.
package store_commit_queue_pkg;

  localparam int SQ_ADDR_W = 32;

  typedef struct packed {
    logic                 ex;
    logic [4:0]           exccode;
    logic [SQ_ADDR_W-1:0] badvaddr;
    logic                 tlb_refill;
  } exception_t;

  typedef struct packed {
    logic [SQ_ADDR_W-1:0] addr;
    logic [SQ_ADDR_W-1:0] wdata;
    logic [3:0]           wstrb;
    logic [1:0]           size;
  } sq_entry_t;

  typedef logic [2:0] sq_state_t;

  localparam sq_state_t SQ_IDLE  = 3'd0;
  localparam sq_state_t SQ_REQ   = 3'd1;
  localparam sq_state_t SQ_RESP  = 3'd2;
  localparam sq_state_t SQ_DONE  = 3'd3;
  localparam sq_state_t SQ_DRAIN = 3'd4;

  localparam logic [4:0] EXCCODE_MOD  = 5'h01;
  localparam logic [4:0] EXCCODE_TLBL = 5'h02;
  localparam logic [4:0] EXCCODE_TLBS = 5'h03;
  localparam logic [4:0] EXCCODE_ADEL = 5'h04;
  localparam logic [4:0] EXCCODE_ADES = 5'h05;

endpackage

// File: rtl/store_commit_queue_if.sv
// Dcache write port between the store commit queue (master) and the dcache (slave).
interface store_commit_queue_if #(parameter int ADDR_W = 32);
  logic              dc_req;
  logic [ADDR_W-1:0] dc_addr;
  logic [ADDR_W-1:0] dc_wdata;
  logic [3:0]        dc_wstrb;
  logic [1:0]        dc_size;
  logic              dc_addr_ok;
  logic              dc_ex;
  logic [4:0]        dc_exccode;
  logic              dc_tlb_refill;
  logic              dc_data_ok;

  modport master (
    output dc_req, dc_addr, dc_wdata, dc_wstrb, dc_size,
    input  dc_addr_ok, dc_ex, dc_exccode, dc_tlb_refill, dc_data_ok
  );

  modport slave (
    input  dc_req, dc_addr, dc_wdata, dc_wstrb, dc_size,
    output dc_addr_ok, dc_ex, dc_exccode, dc_tlb_refill, dc_data_ok
  );
endinterface

// File: rtl/store_commit_queue_sq_fifo.sv
// Generic circular buffer of store entries with flush; storage itself is never reset.
module sq_fifo
  import store_commit_queue_pkg::*;
#(
  parameter int SQ_DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      flush,
  input  logic      enq,
  input  sq_entry_t enq_data,
  input  logic      deq,
  output sq_entry_t head_data,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(SQ_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(SQ_DEPTH);

  sq_entry_t        mem [SQ_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  // Pointers wrap naturally because SQ_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (deq) head <= head + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[tail] <= enq_data;
  end

  assign head_data = mem[head];
  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);

endmodule

// File: rtl/store_commit_queue.sv
// Holds executed stores in program order and writes the oldest one to the dcache only when commit asks.
module store_commit_queue
  import store_commit_queue_pkg::*;
#(
  parameter int SQ_DEPTH = 4,
  parameter int ADDR_W   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    sq_enq_valid,
  output logic                    sq_enq_ready,
  input  logic [ADDR_W-1:0]       sq_enq_addr,
  input  logic [ADDR_W-1:0]       sq_enq_wdata,
  input  logic [3:0]              sq_enq_wstrb,
  input  logic [1:0]              sq_enq_size,
  input  logic                    commit_store_valid,
  output logic                    commit_store_ready,
  output exception_t              commit_store_ex,
  store_commit_queue_if.master    dc,
  output logic                    sq_empty
);

  sq_state_t  state;
  sq_state_t  state_nx;
  sq_entry_t  enq_entry;
  sq_entry_t  head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       enq;
  logic       deq;
  logic       ex_flag;
  logic [4:0] ex_code;
  logic       ex_refill;

  assign enq_entry = '{addr: sq_enq_addr, wdata: sq_enq_wdata,
                       wstrb: sq_enq_wstrb, size: sq_enq_size};

  // Flush outranks both enqueue and the DONE dequeue; the fifo clears itself on flush.
  assign sq_enq_ready = !fifo_full && (state != SQ_DRAIN);
  assign enq          = sq_enq_valid && sq_enq_ready && !flush;
  assign deq          = (state == SQ_DONE) && !flush;

  sq_fifo #(.SQ_DEPTH(SQ_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .enq       (enq),
    .enq_data  (enq_entry),
    .deq       (deq),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= SQ_IDLE;
    else       state <= state_nx;
  end

  // Every path into DONE passes through an address acceptance, so this capture is always fresh.
  always_ff @(posedge clk) begin
    if (state == SQ_REQ && dc.dc_addr_ok) begin
      ex_flag   <= dc.dc_ex;
      ex_code   <= dc.dc_exccode;
      ex_refill <= dc.dc_tlb_refill;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      SQ_IDLE:
        if (commit_store_valid && !flush && !fifo_empty) state_nx = SQ_REQ;
      SQ_REQ:
        if (dc.dc_addr_ok) begin
          // An accepted write must finish its data phase even when flushed; a faulting one has none.
          if (flush) state_nx = dc.dc_ex ? SQ_IDLE : SQ_DRAIN;
          else       state_nx = dc.dc_ex ? SQ_DONE : SQ_RESP;
        end else if (flush) begin
          state_nx = SQ_IDLE;
        end
      SQ_RESP:
        if (flush)               state_nx = dc.dc_data_ok ? SQ_IDLE : SQ_DRAIN;
        else if (dc.dc_data_ok)  state_nx = SQ_DONE;
      SQ_DONE:
        state_nx = SQ_IDLE;
      SQ_DRAIN:
        if (dc.dc_data_ok) state_nx = SQ_IDLE;
      default:
        state_nx = SQ_IDLE;
    endcase
  end

  assign dc.dc_req   = (state == SQ_REQ) && !flush;
  assign dc.dc_addr  = head.addr;
  assign dc.dc_wdata = head.wdata;
  assign dc.dc_wstrb = head.wstrb;
  assign dc.dc_size  = head.size;

  assign commit_store_ready = (state == SQ_DONE) && !flush;
  assign sq_empty           = fifo_empty;

  always_comb begin
    commit_store_ex = '0;
    if (commit_store_ready && ex_flag) begin
      commit_store_ex.ex         = 1'b1;
      commit_store_ex.exccode    = ex_code;
      commit_store_ex.badvaddr   = head.addr;
      commit_store_ex.tlb_refill = ex_refill;
    end
  end

endmodule

// File: tb/tb_store_commit_queue.sv
// Randomized bench for store_commit_queue: a queue model plus a driven dcache predicts every output each cycle.
module tb_store_commit_queue;
  import store_commit_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        sq_enq_valid;
  logic        sq_enq_ready;
  logic [31:0] sq_enq_addr;
  logic [31:0] sq_enq_wdata;
  logic [3:0]  sq_enq_wstrb;
  logic [1:0]  sq_enq_size;
  logic        commit_store_valid;
  logic        commit_store_ready;
  exception_t  commit_store_ex;
  logic        sq_empty;

  store_commit_queue_if #(.ADDR_W(32)) dc();

  store_commit_queue #(.SQ_DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk                (clk),
    .reset              (reset),
    .flush              (flush),
    .sq_enq_valid       (sq_enq_valid),
    .sq_enq_ready       (sq_enq_ready),
    .sq_enq_addr        (sq_enq_addr),
    .sq_enq_wdata       (sq_enq_wdata),
    .sq_enq_wstrb       (sq_enq_wstrb),
    .sq_enq_size        (sq_enq_size),
    .commit_store_valid (commit_store_valid),
    .commit_store_ready (commit_store_ready),
    .commit_store_ex    (commit_store_ex),
    .dc                 (dc.master),
    .sq_empty           (sq_empty)
  );

  always #5 clk = ~clk;

  sq_entry_t  q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       exp_req, exp_ready, exp_drain, pop_now, rnd_enq, exp_exf, exp_refill, prev_ready;
  logic [4:0] exp_code;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic rand_enq();
    sq_enq_valid = 1'($urandom_range(0, 1));
    sq_enq_addr  = $urandom();
    sq_enq_wdata = $urandom();
    sq_enq_wstrb = 4'($urandom());
    sq_enq_size  = 2'($urandom_range(0, 2));
  endtask

  // One clock: check all outputs at negedge, then update the model at the posedge.
  task automatic clock_cycle();
    exception_t ee;
    logic       acc;
    sq_entry_t  ne;
    @(negedge clk);
    ee = '0;
    if (exp_ready && exp_exf) begin
      ee.ex         = 1'b1;
      ee.exccode    = exp_code;
      ee.badvaddr   = q[0].addr;
      ee.tlb_refill = exp_refill;
    end
    check_val("dc_req", 64'(dc.dc_req), 64'(exp_req));
    if (exp_req) begin
      check_val("dc_addr",  64'(dc.dc_addr),  64'(q[0].addr));
      check_val("dc_wdata", 64'(dc.dc_wdata), 64'(q[0].wdata));
      check_val("dc_wstrb", 64'(dc.dc_wstrb), 64'(q[0].wstrb));
      check_val("dc_size",  64'(dc.dc_size),  64'(q[0].size));
    end
    check_val("commit_ready", 64'(commit_store_ready), 64'(exp_ready));
    check_val("ready_adjacent", 64'(commit_store_ready && prev_ready), 64'(0));
    check_val("commit_ex", 64'(commit_store_ex), 64'(ee));
    check_val("enq_ready", 64'(sq_enq_ready), 64'(q.size() < DEPTH && !exp_drain));
    check_val("sq_empty", 64'(sq_empty), 64'(q.size() == 0));
    prev_ready = commit_store_ready;
    acc = !reset && !flush && sq_enq_valid && (q.size() < DEPTH) && !exp_drain;
    ne  = '{addr: sq_enq_addr, wdata: sq_enq_wdata, wstrb: sq_enq_wstrb, size: sq_enq_size};
    @(posedge clk);
    if (reset || flush) q.delete();
    else begin
      if (pop_now) void'(q.pop_front());
      if (acc) q.push_back(ne);
    end
    #1;
    if (rnd_enq) rand_enq();
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] z);
    sq_enq_valid = 1'b1; sq_enq_addr = a; sq_enq_wdata = d; sq_enq_wstrb = s; sq_enq_size = z;
    clock_cycle();
    sq_enq_valid = 1'b0;
  endtask

  // fl: 0 none, 1 flush in REQ, 2 flush in RESP, 3 flush with addr_ok.
  task automatic commit_txn(input int aw, input int dw, input bit ex, input int fl,
                            input logic [4:0] code, input logic refill);
    exp_req = 0; exp_ready = 0; pop_now = 0;
    commit_store_valid = 1'b1;
    clock_cycle();
    commit_store_valid = 1'b0;
    exp_req = 1;
    repeat (aw) clock_cycle();
    if (fl == 1) begin
      flush = 1'b1; exp_req = 0;
      clock_cycle();
      flush = 1'b0;
      return;
    end
    dc.dc_addr_ok = 1'b1; dc.dc_ex = ex; dc.dc_exccode = code; dc.dc_tlb_refill = refill;
    if (fl == 3) begin flush = 1'b1; exp_req = 0; end
    clock_cycle();
    dc.dc_addr_ok = 1'b0; dc.dc_ex = 1'b0; flush = 1'b0; exp_req = 0;
    if (ex) begin
      exp_exf = 1; exp_code = code; exp_refill = refill; exp_ready = 1; pop_now = 1;
      clock_cycle();
      exp_exf = 0; exp_ready = 0; pop_now = 0;
      return;
    end
    if (fl == 2) begin
      flush = 1'b1;
      clock_cycle();
      flush = 1'b0;
    end
    if (fl != 0) exp_drain = 1;
    repeat (dw) clock_cycle();
    dc.dc_data_ok = 1'b1;
    clock_cycle();
    dc.dc_data_ok = 1'b0;
    if (fl != 0) begin
      exp_drain = 0;
      return;
    end
    exp_ready = 1; pop_now = 1;
    clock_cycle();
    exp_ready = 0; pop_now = 0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; commit_store_valid = 1'b0;
    sq_enq_valid = 1'b0; sq_enq_addr = '0; sq_enq_wdata = '0; sq_enq_wstrb = '0; sq_enq_size = '0;
    dc.dc_addr_ok = 1'b0; dc.dc_ex = 1'b0; dc.dc_exccode = '0; dc.dc_tlb_refill = 1'b0; dc.dc_data_ok = 1'b0;
    exp_req = 0; exp_ready = 0; exp_drain = 0; pop_now = 0; rnd_enq = 0; exp_exf = 0;
    exp_refill = 0; exp_code = '0; prev_ready = 0;

    @(posedge clk); #1;
    clock_cycle();
    reset = 1'b0;
    clock_cycle();

    // Two stores, commit with addr_ok two cycles in and data_ok at cycle 4.
    enq(32'h1000, 32'hAABBCCDD, 4'hF, 2'd2);
    enq(32'h1004, 32'h00000011, 4'h1, 2'd0);
    commit_txn(1, 1, 0, 0, '0, 0);
    clock_cycle();

    // Fill to four, hold a fifth, retire one, fifth lands in the wrapped slot.
    enq(32'h2000, 32'h22222222, 4'h3, 2'd1);
    enq(32'h2004, 32'h33333333, 4'hC, 2'd1);
    enq(32'h2008, 32'h44444444, 4'hF, 2'd2);
    sq_enq_valid = 1'b1; sq_enq_addr = 32'h200C; sq_enq_wdata = 32'h55555555;
    sq_enq_wstrb = 4'h8; sq_enq_size = 2'd0;
    clock_cycle();
    clock_cycle();
    commit_txn(0, 1, 0, 0, '0, 0);
    clock_cycle();
    sq_enq_valid = 1'b0;
    while (q.size() > 0) commit_txn(0, 0, 0, 0, '0, 0);
    clock_cycle();

    // TLB store exception on address phase.
    enq(32'h3000, 32'hDEADBEEF, 4'hF, 2'd2);
    commit_txn(1, 0, 1, 0, 5'h3, 1'b1);
    clock_cycle();

    // Flush while requesting, then an empty-queue commit must not start anything.
    enq(32'h4000, 32'h1, 4'h1, 2'd0);
    enq(32'h4004, 32'h2, 4'h1, 2'd0);
    commit_txn(1, 0, 0, 1, '0, 0);
    commit_store_valid = 1'b1;
    clock_cycle();
    commit_store_valid = 1'b0;
    clock_cycle();
    clock_cycle();

    // Flush in IDLE, in RESP, and coincident with address acceptance.
    enq(32'h5000, 32'h5, 4'hF, 2'd2);
    flush = 1'b1;
    clock_cycle();
    flush = 1'b0;
    enq(32'h6000, 32'h6, 4'hF, 2'd2);
    enq(32'h6004, 32'h7, 4'hF, 2'd2);
    commit_txn(0, 2, 0, 2, '0, 0);
    clock_cycle();
    enq(32'h7000, 32'h8, 4'hF, 2'd2);
    commit_txn(1, 1, 0, 3, '0, 0);
    clock_cycle();

    // Reset in the middle of a request.
    enq(32'h8000, 32'h9, 4'hF, 2'd2);
    commit_store_valid = 1'b1;
    clock_cycle();
    commit_store_valid = 1'b0;
    exp_req = 1; reset = 1'b1;
    clock_cycle();
    exp_req = 0; reset = 1'b0;
    clock_cycle();

    // Back-to-back zero-wait commits with concurrent enqueues.
    rnd_enq = 1; rand_enq();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) clock_cycle();
      else commit_txn(0, 0, 0, 0, '0, 0);
    end

    // Random mix of latencies, exceptions and flushes.
    for (int i = 0; i < 250; i++) begin
      int fl, aw, dw;
      bit ex;
      aw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      case ($urandom_range(0, 9))
        0:       fl = 1;
        1:       fl = 2;
        2:       fl = 3;
        default: fl = 0;
      endcase
      ex = (fl == 0) && ($urandom_range(0, 7) == 0);
      repeat ($urandom_range(0, 2)) clock_cycle();
      if (q.size() == 0) clock_cycle();
      else commit_txn(aw, dw, ex, fl, 5'($urandom()), 1'($urandom()));
    end
    rnd_enq = 0; sq_enq_valid = 1'b0;
    clock_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
